// File: rtl/regfile_multiport_sb.sv
// regfile_multiport_sb: two-write-port, NUM_RD-read-port register file with a
// per-register pending-write scoreboard for pipelined writeback hazard tracking.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read same-cycle bypass).
module regfile_multiport_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_RD = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       regWrite1,
    input  logic [ADDR_W-1:0]          destReg1,
    input  logic [DATA_W-1:0]          writeData1,
    input  logic                       regWrite2,
    input  logic [ADDR_W-1:0]          destReg2,
    input  logic [DATA_W-1:0]          writeData2,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    input  logic                       reserveEn,
    input  logic [ADDR_W-1:0]          reserveAddr,
    output logic [NUM_RD-1:0]          rdBusy,
    output logic                       anyBusy
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]       r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]     r_pending;
    logic [NUM_RD*DATA_W-1:0] w_rdData;
    logic [NUM_RD-1:0]        w_rdBusy;

    // Register storage: port 2 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (regWrite1) begin
                r_regs[destReg1] <= writeData1;
            end
            if (regWrite2) begin
                r_regs[destReg2] <= writeData2;
            end
        end
    end

    // Scoreboard: a reserve sets pending and beats a same-cycle writeback clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (reserveEn && (reserveAddr == ADDR_W'(r))) begin
                    r_pending[r] <= 1'b1;
                end else if ((regWrite1 && (destReg1 == ADDR_W'(r))) ||
                             (regWrite2 && (destReg2 == ADDR_W'(r)))) begin
                    r_pending[r] <= 1'b0;
                end
            end
        end
    end

    // Combinational read ports with per-port busy flags (optionally bypassed).
    always_comb begin
        w_rdData = '0;
        w_rdBusy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            w_rdData[k*DATA_W +: DATA_W] = r_regs[rdAddr[k*ADDR_W +: ADDR_W]];
            w_rdBusy[k]                  = r_pending[rdAddr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            // Port 2 is checked last so it overrides port 1 on a collision.
            if (regWrite1 && (destReg1 == rdAddr[k*ADDR_W +: ADDR_W])) begin
                w_rdData[k*DATA_W +: DATA_W] = writeData1;
                w_rdBusy[k]                  = 1'b0;
            end
            if (regWrite2 && (destReg2 == rdAddr[k*ADDR_W +: ADDR_W])) begin
                w_rdData[k*DATA_W +: DATA_W] = writeData2;
                w_rdBusy[k]                  = 1'b0;
            end
`else
            // Stored value only; writes become visible after the clock edge.
`endif
        end
    end

    assign rdData  = w_rdData;
    assign rdBusy  = w_rdBusy;
    assign anyBusy = |r_pending;

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Scoreboard bench for regfile_multiport_sb: directed scenarios then random traffic.
module tb_regfile_multiport_sb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NUM_RD = 6;
    localparam int unsigned NREG   = 8;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      regWrite1 = 1'b0;
    logic [ADDR_W-1:0]         destReg1 = '0;
    logic [DATA_W-1:0]         writeData1 = '0;
    logic                      regWrite2 = 1'b0;
    logic [ADDR_W-1:0]         destReg2 = '0;
    logic [DATA_W-1:0]         writeData2 = '0;
    logic [NUM_RD*ADDR_W-1:0]  rdAddr = '0;
    logic [NUM_RD*DATA_W-1:0]  rdData;
    logic                      reserveEn = 1'b0;
    logic [ADDR_W-1:0]         reserveAddr = '0;
    logic [NUM_RD-1:0]         rdBusy;
    logic                      anyBusy;

    regfile_multiport_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .reset(reset),
        .regWrite1(regWrite1), .destReg1(destReg1), .writeData1(writeData1),
        .regWrite2(regWrite2), .destReg2(destReg2), .writeData2(writeData2),
        .rdAddr(rdAddr), .rdData(rdData),
        .reserveEn(reserveEn), .reserveAddr(reserveAddr),
        .rdBusy(rdBusy), .anyBusy(anyBusy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_RD*DATA_W-1:0] data;
        logic [NUM_RD-1:0]        busy;
        logic                     any;
        string                    tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference state: what the register file architecturally holds.
    logic [DATA_W-1:0] m_regs [NREG];
    bit                m_pend [NREG];

    // Monitor: outputs are combinational, so one expectation per cycle is popped at negedge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (rdData !== e.data) begin
                errors++;
                $display("FAIL %s rdData got %h exp %h", e.tag, rdData, e.data);
            end
            checks++;
            if (rdBusy !== e.busy) begin
                errors++;
                $display("FAIL %s rdBusy got %b exp %b", e.tag, rdBusy, e.busy);
            end
            checks++;
            if (anyBusy !== e.any) begin
                errors++;
                $display("FAIL %s anyBusy got %b exp %b", e.tag, anyBusy, e.any);
            end
        end
    end

    // One clock cycle: drive, queue expected outputs, then advance the model at the edge.
    task automatic cyc(input bit chk, input string tag, input bit rst,
                       input bit w1, input int d1, input logic [DATA_W-1:0] wd1,
                       input bit w2, input int d2, input logic [DATA_W-1:0] wd2,
                       input bit rv, input int ra, input logic [NUM_RD*ADDR_W-1:0] addrs);
        exp_t e;
        bit   hit;
        reset = rst;
        regWrite1 = w1; destReg1 = ADDR_W'(d1); writeData1 = wd1;
        regWrite2 = w2; destReg2 = ADDR_W'(d2); writeData2 = wd2;
        reserveEn = rv; reserveAddr = ADDR_W'(ra);
        rdAddr = addrs;
        if (chk) begin
            e.tag = tag;
            e.any = 1'b0;
            for (int r = 0; r < NREG; r++) e.any = e.any | m_pend[r];
            for (int k = 0; k < NUM_RD; k++) begin
                int a;
                a = int'(addrs[k*ADDR_W +: ADDR_W]);
                e.data[k*DATA_W +: DATA_W] = m_regs[a];
                e.busy[k] = m_pend[a];
`ifdef REGFILE_BYPASS_EN
                hit = 1'b0;
                if (w2 && d2 == a) begin
                    e.data[k*DATA_W +: DATA_W] = wd2; hit = 1'b1;
                end else if (w1 && d1 == a) begin
                    e.data[k*DATA_W +: DATA_W] = wd1; hit = 1'b1;
                end
                if (hit) e.busy[k] = 1'b0;
`else
                hit = 1'b0;
`endif
            end
            q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                bit wr;
                wr = (w1 && d1 == r) || (w2 && d2 == r);
                if (rv && ra == r) m_pend[r] = 1'b1;
                else if (wr)       m_pend[r] = 1'b0;
            end
            if (w1) m_regs[d1] = wd1;
            if (w2) m_regs[d2] = wd2;
        end
        #1;
    endtask

    localparam logic [NUM_RD*ADDR_W-1:0] A_SEQ = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        @(posedge clk); #1;

        // 1: reset with writes/reserve active; state unknown before the first edge.
        cyc(0, "rst0", 1, 1, 2, 32'hFFFF_0001, 1, 3, 32'hFFFF_0002, 1, 4, A_SEQ);
        cyc(1, "rst1", 1, 1, 2, 32'hFFFF_0003, 1, 3, 32'hFFFF_0004, 1, 5, A_SEQ);
        cyc(1, "rst_idle", 0, 0, 0, '0, 0, 0, '0, 0, 0, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2});

        // 2: dual write to different registers.
        cyc(1, "wr_a_b", 0, 1, 0, 32'h0000_000A, 1, 1, 32'h0000_000B, 0, 0, A_SEQ);
        cyc(1, "rd_a_b", 0, 0, 0, '0, 0, 0, '0, 0, 0, A_SEQ);
        cyc(1, "rd_hi", 0, 0, 0, '0, 0, 0, '0, 0, 0, {3'd7, 3'd6, 3'd2, 3'd3, 3'd1, 3'd0});

        // 3: collision on r3, port 2 wins.
        cyc(1, "collide", 0, 1, 3, 32'h1111_1111, 1, 3, 32'h2222_2222, 0, 0, {6{3'd3}});
        cyc(1, "rd_r3", 0, 0, 0, '0, 0, 0, '0, 0, 0, {6{3'd3}});

        // 4: reserve r5, observe busy, then writeback clears it.
        cyc(1, "resv5", 0, 0, 0, '0, 0, 0, '0, 1, 5, {3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0});
        cyc(1, "busy5", 0, 0, 0, '0, 0, 0, '0, 0, 0, {3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0});
        cyc(1, "wb5", 0, 1, 5, 32'h0000_0055, 0, 0, '0, 0, 0, {3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0});
        cyc(1, "clr5", 0, 0, 0, '0, 0, 0, '0, 0, 0, {3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0});

        // 5: reserve beats same-cycle clear; reset drops the reservation.
        cyc(1, "resv_wr4", 0, 0, 0, '0, 1, 4, 32'h0000_0044, 1, 4, {6{3'd4}});
        cyc(1, "rst_pend4", 1, 0, 0, '0, 0, 0, '0, 0, 0, {6{3'd4}});
        cyc(1, "after_rst4", 0, 0, 0, '0, 0, 0, '0, 0, 0, {6{3'd4}});

        // 6: same-cycle read of the register being written (bypass-dependent).
        cyc(1, "byp6", 0, 1, 6, 32'hDEAD_BEEF, 0, 0, '0, 0, 0, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
        cyc(1, "post6", 0, 0, 0, '0, 0, 0, '0, 0, 0, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});

        // Bypass onto a pending register, with a port collision.
        cyc(1, "resv7", 0, 0, 0, '0, 0, 0, '0, 1, 7, {6{3'd7}});
        cyc(1, "byp7", 0, 1, 7, 32'h7777_0001, 1, 7, 32'h7777_0002, 0, 0, {3'd7, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0});

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [NUM_RD*ADDR_W-1:0] addrs;
            addrs = NUM_RD*ADDR_W'($urandom);
            cyc(1, "rand", ($urandom_range(0, 49) == 0),
                $urandom_range(0, 1), int'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), int'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), addrs);
        end

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left got %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
